axis_video_gen: RTL and testbench

- Synthesisable, parametrised AXI4-Stream video source that replaces hand-written bench stimulus.
- Emits frames of H_ACTIVE x V_ACTIVE pixels in bursts of BURST_LEN beats separated by GAP_LEN idle cycles, with programmable line and frame blanking.
- Selectable test pattern; fully honours tready backpressure.
- Feeds the gamma/debug stage and the frame memories in bench and on-board bring-up.

---
 rtl/video_pkg.sv | 35 +++
 rtl/video_pattern.sv | 52 +++++
 rtl/axis_video_gen.sv | 173 +++++++++++++++++
 tb/tb_axis_video_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared encodings for the AXI4-Stream video generator: pattern modes, FSM
// states and the colour-bar lookup.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_LINE_GAP,
    ST_FRAME_GAP
  } state_e;

  // Channel c of bar k is all-ones when bit c of (7-k) is set; channel 0 is
  // the most significant component of the pixel word.
  function automatic logic [95:0] bar_color(input logic [2:0] k, input int unsigned comp_w);
    logic [2:0]  v;
    logic [95:0] ones;
    logic [95:0] r;
    v    = 3'd7 - k;
    ones = (96'd1 << comp_w) - 96'd1;
    r    = '0;
    if (v[0]) r = r | (ones << (2 * comp_w));
    if (v[1]) r = r | (ones << comp_w);
    if (v[2]) r = r | ones;
    return r;
  endfunction

endpackage

// File: rtl/video_pattern.sv
// Pure combinational test-pattern mux: selects the pixel for the beat at
// coordinates (x, y) according to the active mode.
module video_pattern
  import video_pkg::*;
#(
  parameter int COMP_W   = 8,
  parameter int H_ACTIVE = 640,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  mode_e                 mode,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [COMP_W-1:0]     pix_cnt,
  input  logic [3*COMP_W-1:0]   const_pix,
  output logic [3*COMP_W-1:0]   pixel
);

  logic [XW+2:0] bar;
  logic [95:0]   bars;
  logic          x3;
  logic          y3;
  logic          unused_bits;

  if (XW > 3) begin : g_x3
    assign x3 = x[3];
  end else begin : g_no_x3
    assign x3 = 1'b0;
  end

  if (YW > 3) begin : g_y3
    assign y3 = y[3];
  end else begin : g_no_y3
    assign y3 = 1'b0;
  end

  // bar index is always below 8, so only the low three bits carry information
  assign unused_bits = ^{y, bar[XW+2:3]};

  always_comb begin
    bar  = {x, 3'b000} / (XW+3)'(H_ACTIVE);
    bars = bar_color(bar[2:0], COMP_W);
    case (mode)
      MODE_RAMP:  pixel = {3{pix_cnt}};
      MODE_BARS:  pixel = bars[3*COMP_W-1:0];
      MODE_CONST: pixel = const_pix;
      MODE_CHECK: pixel = (x3 ^ y3) ? '1 : '0;
      default:    pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_gen.sv
// AXI4-Stream video source: bursty frame generator with line/frame blanking,
// selectable test patterns and full tready backpressure.
module axis_video_gen
  import video_pkg::*;
#(
  parameter int COMP_W    = 8,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BURST_LEN = 4,
  parameter int GAP_LEN   = 3,
  parameter int LINE_GAP  = 1750,
  parameter int FRAME_GAP = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [3*COMP_W-1:0]   const_pix,
  input  logic [15:0]           frames_req,
  input  logic                  m_axis_video_tready,
  output logic [3*COMP_W-1:0]   m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int PW   = 3 * COMP_W;
  localparam int XW   = $clog2(H_ACTIVE) + 1;
  localparam int YW   = $clog2(V_ACTIVE) + 1;
  localparam int BW   = $clog2(BURST_LEN) + 1;
  localparam int GMAX = (GAP_LEN > LINE_GAP) ? ((GAP_LEN > FRAME_GAP) ? GAP_LEN : FRAME_GAP)
                                             : ((LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP);
  localparam int GW   = $clog2(GMAX) + 1;

  state_e          state, state_nx;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [COMP_W-1:0] pix_cnt;
  logic [BW-1:0]   burst_cnt;
  logic [GW-1:0]   gap_cnt, gap_ld;
  mode_e           mode_r, pat_mode;
  logic [PW-1:0]   const_r, pat_const, pixel, tdata_r;
  logic [15:0]     frames_req_r, frame_cnt_r, cnt_inc;
  logic            tuser_r, tlast_r, last_line_r, frame_done_r;
  logic            xfer, frame_end, stop_cur, stop_inc, load, gap_start;

  assign xfer      = (state == ST_BURST) && m_axis_video_tready;
  assign frame_end = xfer && tlast_r && last_line_r;
  assign cnt_inc   = (frame_cnt_r == '1) ? frame_cnt_r : frame_cnt_r + 16'd1;
  assign stop_cur  = !enable || ((frames_req_r != '0) && (frame_cnt_r == frames_req_r));
  assign stop_inc  = !enable || ((frames_req_r != '0) && (cnt_inc == frames_req_r));

  // x/y/pix_cnt address the next beat to load, so the first beat of a frame
  // must see the live mode/const inputs while they are being latched in IDLE.
  assign pat_mode  = (state == ST_IDLE) ? mode_e'(mode) : mode_r;
  assign pat_const = (state == ST_IDLE) ? const_pix : const_r;

  video_pattern #(
    .COMP_W   (COMP_W),
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pattern (
    .mode      (pat_mode),
    .x         (x),
    .y         (y),
    .pix_cnt   (pix_cnt),
    .const_pix (pat_const),
    .pixel     (pixel)
  );

  always_comb begin
    state_nx  = state;
    gap_start = 1'b0;
    gap_ld    = '0;
    case (state)
      ST_IDLE: if (enable) state_nx = ST_BURST;
      ST_BURST: if (xfer) begin
        if (tlast_r && last_line_r) begin
          if (FRAME_GAP == 0) begin
            state_nx = stop_inc ? ST_IDLE : ST_BURST;
          end else begin
            state_nx  = ST_FRAME_GAP;
            gap_start = 1'b1;
            gap_ld    = GW'(FRAME_GAP - 1);
          end
        end else if (tlast_r) begin
          if (LINE_GAP != 0) begin
            state_nx  = ST_LINE_GAP;
            gap_start = 1'b1;
            gap_ld    = GW'(LINE_GAP - 1);
          end
        end else if ((burst_cnt == BW'(BURST_LEN - 1)) && (GAP_LEN != 0)) begin
          state_nx  = ST_GAP;
          gap_start = 1'b1;
          gap_ld    = GW'(GAP_LEN - 1);
        end
      end
      ST_GAP, ST_LINE_GAP: if (gap_cnt == '0) state_nx = ST_BURST;
      ST_FRAME_GAP: if (gap_cnt == '0) state_nx = stop_cur ? ST_IDLE : ST_BURST;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign load = (state_nx == ST_BURST) && ((state != ST_BURST) || xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      x            <= '0;
      y            <= '0;
      pix_cnt      <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      mode_r       <= MODE_RAMP;
      const_r      <= '0;
      frames_req_r <= '0;
      frame_cnt_r  <= '0;
      tdata_r      <= '0;
      tuser_r      <= 1'b0;
      tlast_r      <= 1'b0;
      last_line_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state        <= state_nx;
      frame_done_r <= frame_end;
      if ((state == ST_IDLE) && enable) begin
        mode_r       <= mode_e'(mode);
        const_r      <= const_pix;
        frames_req_r <= frames_req;
        frame_cnt_r  <= '0;
      end else if (frame_end) begin
        frame_cnt_r  <= cnt_inc;
      end
      if (gap_start) gap_cnt <= gap_ld;
      else if ((state != ST_BURST) && (state != ST_IDLE)) gap_cnt <= gap_cnt - GW'(1);
      if (xfer) begin
        burst_cnt <= (tlast_r || (burst_cnt == BW'(BURST_LEN - 1))) ? '0 : burst_cnt + BW'(1);
      end
      if (load) begin
        tdata_r     <= pixel;
        tuser_r     <= (x == '0) && (y == '0);
        tlast_r     <= (x == XW'(H_ACTIVE - 1));
        last_line_r <= (y == YW'(V_ACTIVE - 1));
        if (x == XW'(H_ACTIVE - 1)) begin
          x <= '0;
          if (y == YW'(V_ACTIVE - 1)) begin
            y       <= '0;
            pix_cnt <= '0;
          end else begin
            y       <= y + YW'(1);
            pix_cnt <= pix_cnt + COMP_W'(1);
          end
        end else begin
          x       <= x + XW'(1);
          pix_cnt <= pix_cnt + COMP_W'(1);
        end
      end
    end
  end

  assign m_axis_video_tdata  = tdata_r;
  assign m_axis_video_tvalid = (state == ST_BURST);
  assign m_axis_video_tuser  = tuser_r;
  assign m_axis_video_tlast  = tlast_r;
  assign busy                = (state != ST_IDLE);
  assign frame_done          = frame_done_r;
  assign frame_cnt           = frame_cnt_r;

endmodule

// File: tb/tb_axis_video_gen.sv
// Self-checking bench for axis_video_gen: table-driven frame runs through a
// scoreboard, plus hand-written reset, stop and zero-gap sequences.
module tb_axis_video_gen;
  import video_pkg::*;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int FG = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] const_pix = '0;
  logic [15:0] frames_req = '0;
  logic        tready = 1'b1;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, busy, frame_done;
  logic [15:0] frame_cnt;

  logic        z_enable = 1'b0;
  logic [1:0]  z_mode = 2'd0;
  logic [23:0] z_const = '0;
  logic [15:0] z_frames = '0;
  logic        z_tready = 1'b1;
  logic [23:0] z_tdata;
  logic        z_tvalid, z_tuser, z_tlast, z_busy, z_frame_done;
  logic [15:0] z_frame_cnt;

  always #5 clk = ~clk;

  axis_video_gen #(
    .COMP_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(4),
    .GAP_LEN(3), .LINE_GAP(5), .FRAME_GAP(FG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .const_pix(const_pix),
    .frames_req(frames_req), .m_axis_video_tready(tready),
    .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
    .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  axis_video_gen #(
    .COMP_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(4),
    .GAP_LEN(0), .LINE_GAP(0), .FRAME_GAP(0)
  ) dut_z (
    .clk(clk), .rst(rst), .enable(z_enable), .mode(z_mode), .const_pix(z_const),
    .frames_req(z_frames), .m_axis_video_tready(z_tready),
    .m_axis_video_tdata(z_tdata), .m_axis_video_tvalid(z_tvalid),
    .m_axis_video_tuser(z_tuser), .m_axis_video_tlast(z_tlast),
    .busy(z_busy), .frame_done(z_frame_done), .frame_cnt(z_frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    int          off;
    int          idx;
    bit          tchk;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] cpix;
    logic [15:0] frames;
    bit          rnd;
    int          exp_cnt;
  } vec_t;

  beat_t sb[$];

  function automatic logic [23:0] model_pix(input logic [1:0] m, input logic [23:0] c, input int i);
    int x, y, k;
    logic [2:0] v;
    x = i % H;
    y = i / H;
    case (m)
      2'd0: return {3{8'(i)}};
      2'd1: begin
        k = (x * 8) / H;
        v = 3'(7 - k);
        return {(v[0] ? 8'hFF : 8'h00), (v[1] ? 8'hFF : 8'h00), (v[2] ? 8'hFF : 8'h00)};
      end
      2'd2: return c;
      default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push_frames(input logic [1:0] m, input logic [23:0] c, input int frames, input bit tchk);
    beat_t b;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < H * V; i++) begin
        b.data = model_pix(m, c, i);
        b.user = (i == 0);
        b.last = ((i % H) == H - 1);
        b.off  = 30 * (i / H) + (i % H) + 3 * ((i % H) / 4);
        b.idx  = i;
        b.tchk = tchk;
        sb.push_back(b);
      end
    end
  endtask

  // scoreboard monitor: sampled on the falling edge, away from the active edge
  int          cyc = 0;
  int          base = 0;
  int          done_cnt = 0;
  time         done_t = 0;
  bit          sb_on = 1'b0;
  bit          stall = 1'b0;
  logic [23:0] hd;
  logic        hu, hl;
  beat_t       e;

  always @(negedge clk) begin
    cyc++;
    if (sb_on) begin
      if (stall) begin
        check("hold_valid", tvalid, 1);
        check("hold_data", tdata, hd);
        check("hold_user", tuser, hu);
        check("hold_last", tlast, hl);
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t", tdata, $time);
        end else begin
          e = sb.pop_front();
          check("beat_data", tdata, e.data);
          check("beat_user", tuser, e.user);
          check("beat_last", tlast, e.last);
          if (e.idx == 0) base = cyc;
          else if (e.tchk) check("beat_time", cyc - base, e.off);
        end
      end
      stall = tvalid && !tready;
      hd = tdata;
      hu = tuser;
      hl = tlast;
    end else begin
      stall = 1'b0;
    end
    if (frame_done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  bit rnd_rdy = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic wait_idle(input string name, input int limit, output time t);
    int k;
    k = 0;
    while ((k < limit) && busy) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
    t = $time;
  endtask

  task automatic run_vec(input vec_t v);
    time t;
    sb_on    = 1'b1;
    done_cnt = 0;
    rnd_rdy  = v.rnd;
    push_frames(v.mode, v.cpix, int'(v.frames), !v.rnd);
    @(negedge clk);
    mode = v.mode; const_pix = v.cpix; frames_req = v.frames; enable = 1'b1;
    @(negedge clk);
    check("first_beat_latency", tvalid, 1);
    check("busy_running", busy, 1);
    wait_idle("frame_run_timeout", 4000, t);
    enable = 1'b0;
    check("frame_cnt", frame_cnt, v.exp_cnt);
    check("frame_done_pulses", done_cnt, v.exp_cnt);
    check("beats_outstanding", sb.size(), 0);
    check("frame_gap_len", 32'((t - done_t) / 10), FG);
    rnd_rdy = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    time  t;
    int   k;
    int   extra;
    vecs[0] = '{mode: 2'd0, cpix: 24'h0,      frames: 16'd1, rnd: 1'b0, exp_cnt: 1};
    vecs[1] = '{mode: 2'd0, cpix: 24'h0,      frames: 16'd1, rnd: 1'b1, exp_cnt: 1};
    vecs[2] = '{mode: 2'd1, cpix: 24'h0,      frames: 16'd1, rnd: 1'b0, exp_cnt: 1};
    vecs[3] = '{mode: 2'd2, cpix: 24'hA5C3E1, frames: 16'd2, rnd: 1'b0, exp_cnt: 2};
    vecs[4] = '{mode: 2'd3, cpix: 24'h0,      frames: 16'd1, rnd: 1'b1, exp_cnt: 1};

    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // continuous mode, enable dropped during the second frame
    sb_on = 1'b1;
    done_cnt = 0;
    push_frames(2'd0, 24'h0, 2, 1'b1);
    @(negedge clk);
    mode = 2'd0; frames_req = 16'd0; enable = 1'b1;
    k = 0;
    while ((k < 1000) && (done_cnt < 1)) begin
      @(negedge clk);
      k++;
    end
    check("cont_frame1_done", done_cnt, 1);
    repeat (20) @(negedge clk);
    check("cont_in_frame2", busy, 1);
    enable = 1'b0;
    wait_idle("cont_stop_timeout", 1000, t);
    check("cont_frame_cnt", frame_cnt, 2);
    check("cont_done_pulses", done_cnt, 2);
    check("cont_beats_outstanding", sb.size(), 0);
    check("cont_frame_gap_len", 32'((t - done_t) / 10), FG);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (tvalid || busy) extra++;
    end
    check("cont_no_frame3", extra, 0);
    sb.delete();

    // reset in the middle of line 2 at x=7
    sb_on = 1'b0;
    @(negedge clk);
    mode = 2'd0; frames_req = 16'd1; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    k = 0;
    while ((k < 500) && !(tvalid && (tdata == 24'h272727))) begin
      @(negedge clk);
      k++;
    end
    check("reached_x7_y2", tdata, 24'h272727);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tvalid", tvalid, 0);
    check("midrst_tdata", tdata, 0);
    check("midrst_tuser", tuser, 0);
    check("midrst_tlast", tlast, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_still_idle", busy, 0);
    run_vec(vecs[0]);

    // zero-gap instance: back-to-back frames of constant pixels
    @(negedge clk);
    z_mode = 2'd2; z_const = 24'h123456; z_frames = 16'd2; z_enable = 1'b1;
    for (int i = 0; i < 2 * H * V; i++) begin
      @(negedge clk);
      check("z_valid", z_tvalid, 1);
      check("z_data", z_tdata, 24'h123456);
      check("z_user", z_tuser, (i % (H * V)) == 0);
      check("z_last", z_tlast, (i % H) == H - 1);
      check("z_done", z_frame_done, i == H * V);
    end
    @(negedge clk);
    check("z_done_end", z_frame_done, 1);
    check("z_valid_end", z_tvalid, 0);
    check("z_busy_end", z_busy, 0);
    check("z_frame_cnt", z_frame_cnt, 2);
    z_enable = 1'b0;
    @(negedge clk);
    check("z_idle_after", z_tvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
